// File: rtl/gf180mcu_fd_sc_mcu9t5v0__clkdiv_prog.sv
// Programmable 50%-duty clock divider with a valid/ready config port.
// New DIV/INV settings take effect only on whole-period boundaries, so the output never glitches.
module gf180mcu_fd_sc_mcu9t5v0__clkdiv_prog #(
  parameter int WIDTH = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             EN,
  input  logic [WIDTH-1:0] DIV,
  input  logic             INV,
  input  logic             CFG_VALID,
  output logic             CFG_READY,
  output logic             Z,
  output logic             TICK,
  output logic             BUSY
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STOP = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] div_act_q, div_act_d;
  logic [WIDTH-1:0] div_sh_q, div_sh_d;
  logic             inv_act_q, inv_act_d;
  logic             inv_sh_q, inv_sh_d;
  logic             pend_q, pend_d;
  logic             ph_q, ph_d;
  logic             tick_q, tick_d;
  logic             z_q, z_d;

  logic active;
  logic at_max;
  logic bnd;
  logic xfer;

  assign active = (state_q != IDLE);
  assign at_max = (cnt_q == div_act_q);
  assign bnd    = active & at_max & ph_q;
  assign xfer   = CFG_VALID & ~pend_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    div_act_d = div_act_q;
    div_sh_d  = div_sh_q;
    inv_act_d = inv_act_q;
    inv_sh_d  = inv_sh_q;
    pend_d    = pend_q;
    ph_d      = ph_q;
    tick_d    = active & at_max & ~ph_q;

    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        ph_d  = 1'b0;
        if (xfer) begin
          div_act_d = DIV;
          inv_act_d = INV;
        end
        if (EN) state_d = RUN;
      end
      RUN, STOP: begin
        if (at_max) begin
          cnt_d = '0;
          ph_d  = ~ph_q;
        end else begin
          cnt_d = cnt_q + WIDTH'(1);
        end
        // A transfer on the boundary cycle lands in shadow and waits a period.
        if (bnd && pend_q) begin
          div_act_d = div_sh_q;
          inv_act_d = inv_sh_q;
          pend_d    = 1'b0;
        end else if (xfer) begin
          div_sh_d = DIV;
          inv_sh_d = INV;
          pend_d   = 1'b1;
        end
        if (state_q == RUN) begin
          if (!EN) state_d = STOP;
        end else if (EN) begin
          state_d = RUN;
        end else if (bnd) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        ph_d    = 1'b0;
      end
    endcase

    if (RST) begin
      state_d   = IDLE;
      cnt_d     = '0;
      div_act_d = '0;
      div_sh_d  = '0;
      inv_act_d = 1'b0;
      inv_sh_d  = 1'b0;
      pend_d    = 1'b0;
      ph_d      = 1'b0;
      tick_d    = 1'b0;
    end

    z_d = ph_d ^ inv_act_d;
  end

  always_ff @(posedge CLK) begin
    state_q   <= state_d;
    cnt_q     <= cnt_d;
    div_act_q <= div_act_d;
    div_sh_q  <= div_sh_d;
    inv_act_q <= inv_act_d;
    inv_sh_q  <= inv_sh_d;
    pend_q    <= pend_d;
    ph_q      <= ph_d;
    tick_q    <= tick_d;
    z_q       <= z_d;
  end

  assign Z         = z_q;
  assign TICK      = tick_q;
  assign BUSY      = active;
  assign CFG_READY = ~pend_q;

endmodule
